// File: rtl/led_fade_ctrl_if.sv
// Command/status bundle between a fade sequencer client and led_fade_ctrl.
// master drives the requests and configuration; slave returns duty/busy/done.
interface led_fade_ctrl_if #(
  parameter int DUTY_W = 14,
  parameter int HOLD_W = 8,
  parameter int CYC_W  = 8
);
  logic              start;
  logic              stop;
  logic              period_tick;
  logic [DUTY_W-1:0] step;
  logic [DUTY_W-1:0] max_duty;
  logic [HOLD_W-1:0] hold;
  logic [CYC_W-1:0]  cycles;
  logic [DUTY_W-1:0] duty;
  logic              busy;
  logic              done;

  modport master (
    output start, stop, period_tick, step, max_duty, hold, cycles,
    input  duty, busy, done
  );

  modport slave (
    input  start, stop, period_tick, step, max_duty, hold, cycles,
    output duty, busy, done
  );
endinterface

// File: rtl/led_fade_ctrl.sv
// LED fade sequencer: ramps a PWM duty value up/down on PWM period ticks,
// dwelling at top and bottom, for a set number of cycles or until stopped.
module led_fade_ctrl #(
  parameter int DUTY_W = 14,
  parameter int HOLD_W = 8,
  parameter int CYC_W  = 8
) (
  input logic             clk,
  input logic             rst,
  led_fade_ctrl_if.slave  fade
);

  typedef enum logic [2:0] {
    IDLE,
    RAMP_UP,
    HOLD_HI,
    RAMP_DN,
    HOLD_LO
  } state_t;

  state_t            state;
  logic [DUTY_W-1:0] duty_r;
  logic [DUTY_W-1:0] step_r;
  logic [DUTY_W-1:0] max_r;
  logic [HOLD_W-1:0] hold_r;
  logic [HOLD_W-1:0] hold_cnt;
  logic [CYC_W-1:0]  cycles_r;
  logic [CYC_W-1:0]  cyc_cnt;
  logic              busy_r;
  logic              done_r;
  logic              stop_pend;

  logic [DUTY_W:0]   up_sum;
  logic              up_hit;
  logic              dn_hit;
  logic [DUTY_W-1:0] dn_val;
  logic              stop_eff;
  logic              hold_done;
  logic [CYC_W:0]    cyc_next;
  logic              last_cycle;
  logic              cfg_bad;
  logic              do_down;

  // One extra bit on the ramp-up sum so a large step cannot wrap past the ceiling.
  assign up_sum     = {1'b0, duty_r} + {1'b0, step_r};
  assign up_hit     = up_sum >= {1'b0, max_r};
  assign dn_hit     = duty_r <= step_r;
  assign dn_val     = duty_r - step_r;
  assign stop_eff   = stop_pend | fade.stop;
  assign hold_done  = hold_cnt == hold_r;
  assign cyc_next   = {1'b0, cyc_cnt} + {{CYC_W{1'b0}}, 1'b1};
  assign last_cycle = (cycles_r != '0) && (cyc_next == {1'b0, cycles_r});
  assign cfg_bad    = (fade.step == '0) || (fade.max_duty == '0);

  // A pending stop turns the upper half of the sequence into a ramp-down step.
  assign do_down = fade.period_tick &&
                   ((state == RAMP_DN) ||
                    (stop_eff && ((state == RAMP_UP) || (state == HOLD_HI))));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      duty_r    <= '0;
      step_r    <= '0;
      max_r     <= '0;
      hold_r    <= '0;
      hold_cnt  <= '0;
      cycles_r  <= '0;
      cyc_cnt   <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      stop_pend <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (state == IDLE) begin
        duty_r <= '0;
        if (fade.start && !fade.stop) begin
          step_r   <= fade.step;
          max_r    <= fade.max_duty;
          hold_r   <= fade.hold;
          cycles_r <= fade.cycles;
          hold_cnt <= '0;
          cyc_cnt  <= '0;
          if (cfg_bad) begin
            done_r <= 1'b1;
          end else begin
            state  <= RAMP_UP;
            busy_r <= 1'b1;
          end
        end
      end else begin
        if (fade.stop) begin
          stop_pend <= 1'b1;
        end
        if (do_down) begin
          if (dn_hit) begin
            duty_r   <= '0;
            hold_cnt <= '0;
            if (stop_eff) begin
              state     <= IDLE;
              busy_r    <= 1'b0;
              done_r    <= 1'b1;
              stop_pend <= 1'b0;
            end else begin
              state <= HOLD_LO;
            end
          end else begin
            duty_r <= dn_val;
            state  <= RAMP_DN;
          end
        end else if (fade.period_tick) begin
          case (state)
            RAMP_UP: begin
              if (up_hit) begin
                duty_r   <= max_r;
                hold_cnt <= '0;
                state    <= HOLD_HI;
              end else begin
                duty_r <= up_sum[DUTY_W-1:0];
              end
            end
            HOLD_HI: begin
              if (hold_done) begin
                state <= RAMP_DN;
              end else begin
                hold_cnt <= hold_cnt + 1'b1;
              end
            end
            HOLD_LO: begin
              if (stop_eff || (hold_done && last_cycle)) begin
                state     <= IDLE;
                busy_r    <= 1'b0;
                done_r    <= 1'b1;
                stop_pend <= 1'b0;
              end else if (hold_done) begin
                // Endless mode parks the counter at all-ones instead of wrapping.
                if (cyc_cnt != '1) begin
                  cyc_cnt <= cyc_cnt + 1'b1;
                end
                state <= RAMP_UP;
              end else begin
                hold_cnt <= hold_cnt + 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign fade.duty = duty_r;
  assign fade.busy = busy_r;
  assign fade.done = done_r;

endmodule
